// File: rtl/regfile_sb_if.sv
// Bus bundle between issue/writeback and the register file: read ports,
// write port, reservation request and scoreboard status.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs1_busy;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_busy;
    logic            we;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ok;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1_addr, rs2_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rs1_data, rs1_busy, rs2_data, rs2_busy, rsv_ok, busy_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
        output rs1_data, rs1_busy, rs2_data, rs2_busy, rsv_ok, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// x0 hardwired to zero, optional write bypass and a busy scoreboard.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] w_regs [NREGS];
    logic [NREGS-1:0] w_busy;
    logic            w_wr_acc;
    logic            w_rsv_acc;
    logic            w_rsv_ok;
    logic            w_cnt_inc;
    logic            w_cnt_dec;
    logic [AW:0]     r_busy_cnt;

    logic [AW-1:0]   w_rd_addr [2];
    logic [XLEN-1:0] w_rd_data [2];
    logic            w_rd_busy [2];

    assign w_wr_acc  = bus.we && (bus.wr_addr != '0);
    assign w_rsv_ok  = rst || (bus.rsv_addr == '0) || !w_busy[bus.rsv_addr] ||
                       (bus.we && (bus.wr_addr == bus.rsv_addr));
    assign w_rsv_acc = bus.rsv_en && (bus.rsv_addr != '0) && w_rsv_ok;

    // Storage and busy bit per register; entry 0 is constant zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
                assign w_busy[gi] = 1'b0;
            end else begin : g_arch
                logic [XLEN-1:0] r_data;
                logic            r_busy;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_data <= '0;
                    end else if (w_wr_acc && (bus.wr_addr == AW'(gi))) begin
                        r_data <= bus.wr_data;
                    end
                end

                // A reservation in the same cycle as the retiring write wins.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_busy <= 1'b0;
                    end else if (w_rsv_acc && (bus.rsv_addr == AW'(gi))) begin
                        r_busy <= 1'b1;
                    end else if (w_wr_acc && (bus.wr_addr == AW'(gi))) begin
                        r_busy <= 1'b0;
                    end
                end

                assign w_regs[gi] = r_data;
                assign w_busy[gi] = r_busy;
            end
        end
    endgenerate

    assign w_rd_addr[0] = bus.rs1_addr;
    assign w_rd_addr[1] = bus.rs2_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                w_rd_data[gi] = w_regs[w_rd_addr[gi]];
                w_rd_busy[gi] = w_busy[w_rd_addr[gi]];
                if ((BYPASS != 0) && bus.we && (bus.wr_addr == w_rd_addr[gi])) begin
                    w_rd_data[gi] = bus.wr_data;
                    w_rd_busy[gi] = 1'b0;
                end
                if (rst || (w_rd_addr[gi] == '0)) begin
                    w_rd_data[gi] = '0;
                    w_rd_busy[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Count moves only when a busy bit actually changes state.
    assign w_cnt_inc = w_rsv_acc && !w_busy[bus.rsv_addr];
    assign w_cnt_dec = w_wr_acc && w_busy[bus.wr_addr] &&
                       !(w_rsv_acc && (bus.rsv_addr == bus.wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
        end else if (w_cnt_dec && !w_cnt_inc) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
        end
    end

    assign bus.rs1_data = w_rd_data[0];
    assign bus.rs1_busy = w_rd_busy[0];
    assign bus.rs2_data = w_rd_data[1];
    assign bus.rs2_busy = w_rd_busy[1];
    assign bus.rsv_ok   = w_rsv_ok;
    assign bus.busy_cnt = r_busy_cnt;
endmodule
